// File: rtl/arith_op_sequencer_pkg.sv
// arith_op_sequencer_pkg
//   Shared definitions for the arithmetic opcode sequencer and the
//   arithmetic unit wrapper that consumes its opcodes.
//   Contents: opcode width, opcode type, sequencer state enum.
package arith_op_sequencer_pkg;

   localparam int unsigned OPCODE_W = 2;

   typedef logic [OPCODE_W-1:0] opcode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

endpackage

// File: rtl/arith_op_sequencer_if.sv
// arith_op_sequencer_if
//   Control/status bundle between a controller and arith_op_sequencer.
//   Controller -> sequencer:
//     i_enable     run permission
//     i_trigger    start request (rising-edge sensitive)
//     i_program    opcode table, slot k = bits [2k+1:2k]
//     i_last_slot  index of final slot
//     i_dwell      cycles per slot minus one
//     i_loop       1 = wrap after last slot, 0 = single pass
//   Sequencer -> controller / arithmetic unit:
//     o_opcode, o_slot, o_busy, o_slot_start, o_result_valid, o_done
interface arith_op_sequencer_if #(
   parameter int unsigned SLOTS_LOG2 = 3,
   parameter int unsigned DWELL_W    = 16
);
   import arith_op_sequencer_pkg::*;

   localparam int unsigned PROG_W = OPCODE_W * (2 ** SLOTS_LOG2);

   logic                  i_enable;
   logic                  i_trigger;
   logic [PROG_W-1:0]     i_program;
   logic [SLOTS_LOG2-1:0] i_last_slot;
   logic [DWELL_W-1:0]    i_dwell;
   logic                  i_loop;

   opcode_t               o_opcode;
   logic [SLOTS_LOG2-1:0] o_slot;
   logic                  o_busy;
   logic                  o_slot_start;
   logic                  o_result_valid;
   logic                  o_done;

   modport slave (
      input  i_enable, i_trigger, i_program, i_last_slot, i_dwell, i_loop,
      output o_opcode, o_slot, o_busy, o_slot_start, o_result_valid, o_done
   );

   modport master (
      output i_enable, i_trigger, i_program, i_last_slot, i_dwell, i_loop,
      input  o_opcode, o_slot, o_busy, o_slot_start, o_result_valid, o_done
   );

endinterface

// File: rtl/arith_seq_edge_detect.sv
// arith_seq_edge_detect
//   Rising-edge detector. The delayed copy resets to 1 so a signal held
//   high across reset release is not seen as a new edge.
//   Ports:
//     i_clk   clock
//     i_rst   synchronous active-high reset
//     i_sig   monitored signal
//     o_rise  combinational i_sig & ~delayed(i_sig)
module arith_seq_edge_detect (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_rise
);

   logic r_sig_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sig_q <= 1'b1;
      end else begin
         r_sig_q <= i_sig;
      end
   end

   assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/arith_op_sequencer.sv
// arith_op_sequencer
//   Steps an arithmetic unit through a latched table of 2-bit opcodes,
//   holding each slot for (dwell+1) cycles, single-pass or looping.
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  synchronous active-high reset
//     bus    arith_op_sequencer_if.slave (controls in, status out)
//   o_busy is decoded straight from the state register; every other
//   output is registered.
module arith_op_sequencer
   import arith_op_sequencer_pkg::*;
#(
   parameter int unsigned SLOTS_LOG2 = 3,
   parameter int unsigned DWELL_W    = 16,
   parameter int unsigned ALU_LAT    = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   arith_op_sequencer_if.slave   bus
);

   localparam int unsigned PROG_W = OPCODE_W * (2 ** SLOTS_LOG2);
   localparam logic [2:0]  LAT    = 3'(ALU_LAT);

   seq_state_e            r_state;
   logic [PROG_W-1:0]     r_prog;
   logic [SLOTS_LOG2-1:0] r_last;
   logic [DWELL_W-1:0]    r_dwell;
   logic                  r_loop;
   logic [DWELL_W-1:0]    r_cnt;
   logic [2:0]            r_lat;
   opcode_t               r_opcode;
   logic [SLOTS_LOG2-1:0] r_slot;
   logic                  r_slot_start;
   logic                  r_rv;
   logic                  r_done;

   logic                  w_rise;
   logic                  w_slot_end;
   logic                  w_seq_end;
   logic [SLOTS_LOG2-1:0] w_next_slot;
   logic [2:0]            w_lat_inc;

   arith_seq_edge_detect u_edge (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_sig  (bus.i_trigger),
      .o_rise (w_rise)
   );

   assign w_slot_end  = (r_cnt == r_dwell);
   assign w_seq_end   = w_slot_end && (r_slot == r_last);
   assign w_next_slot = w_seq_end ? '0 : r_slot + SLOTS_LOG2'(1);
   // Latency counter saturates at LAT, so a slot shorter than LAT never
   // shows valid and nothing carries into the next slot.
   assign w_lat_inc   = (r_lat == LAT) ? r_lat : r_lat + 3'd1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_prog       <= '0;
         r_last       <= '0;
         r_dwell      <= '0;
         r_loop       <= 1'b0;
         r_cnt        <= '0;
         r_lat        <= '0;
         r_opcode     <= '0;
         r_slot       <= '0;
         r_slot_start <= 1'b0;
         r_rv         <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rise && bus.i_enable) begin
                  r_state      <= ST_RUN;
                  r_prog       <= bus.i_program;
                  r_last       <= bus.i_last_slot;
                  r_dwell      <= bus.i_dwell;
                  r_loop       <= bus.i_loop;
                  r_cnt        <= '0;
                  r_lat        <= '0;
                  r_slot       <= '0;
                  r_opcode     <= bus.i_program[OPCODE_W-1:0];
                  r_slot_start <= 1'b1;
                  r_rv         <= (LAT == 3'd0);
               end
            end
            ST_RUN: begin
               if (!bus.i_enable || (w_seq_end && !r_loop)) begin
                  // Abort and normal completion share the return path;
                  // only completion raises Done.
                  r_state      <= ST_IDLE;
                  r_cnt        <= '0;
                  r_lat        <= '0;
                  r_slot       <= '0;
                  r_opcode     <= '0;
                  r_slot_start <= 1'b0;
                  r_rv         <= 1'b0;
                  r_done       <= bus.i_enable;
               end else if (w_slot_end) begin
                  r_cnt        <= '0;
                  r_lat        <= '0;
                  r_slot       <= w_next_slot;
                  r_opcode     <= r_prog[OPCODE_W*w_next_slot +: OPCODE_W];
                  r_slot_start <= 1'b1;
                  r_rv         <= (LAT == 3'd0);
               end else begin
                  r_cnt        <= r_cnt + DWELL_W'(1);
                  r_lat        <= w_lat_inc;
                  r_slot_start <= 1'b0;
                  r_rv         <= (w_lat_inc == LAT);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_busy         = (r_state == ST_RUN);
   assign bus.o_opcode       = r_opcode;
   assign bus.o_slot         = r_slot;
   assign bus.o_slot_start   = r_slot_start;
   assign bus.o_result_valid = r_rv;
   assign bus.o_done         = r_done;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// tb_arith_op_sequencer
//   Directed bench for arith_op_sequencer. Three instances share the same
//   stimulus and differ only in ALU_LAT (0, 1, 5).
module tb_arith_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        trigger;
   logic [15:0] program_tbl;
   logic [2:0]  last_slot;
   logic [15:0] dwell;
   logic        loop_en;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   arith_op_sequencer_if #(.SLOTS_LOG2(3), .DWELL_W(16)) bus1 ();
   arith_op_sequencer_if #(.SLOTS_LOG2(3), .DWELL_W(16)) bus5 ();
   arith_op_sequencer_if #(.SLOTS_LOG2(3), .DWELL_W(16)) bus0 ();

   assign bus1.i_enable = enable;   assign bus1.i_trigger   = trigger;
   assign bus1.i_program = program_tbl; assign bus1.i_last_slot = last_slot;
   assign bus1.i_dwell  = dwell;    assign bus1.i_loop      = loop_en;
   assign bus5.i_enable = enable;   assign bus5.i_trigger   = trigger;
   assign bus5.i_program = program_tbl; assign bus5.i_last_slot = last_slot;
   assign bus5.i_dwell  = dwell;    assign bus5.i_loop      = loop_en;
   assign bus0.i_enable = enable;   assign bus0.i_trigger   = trigger;
   assign bus0.i_program = program_tbl; assign bus0.i_last_slot = last_slot;
   assign bus0.i_dwell  = dwell;    assign bus0.i_loop      = loop_en;

   arith_op_sequencer #(.SLOTS_LOG2(3), .DWELL_W(16), .ALU_LAT(1)) u_dut (
      .i_clk (clk), .i_rst (rst), .bus (bus1.slave)
   );
   arith_op_sequencer #(.SLOTS_LOG2(3), .DWELL_W(16), .ALU_LAT(5)) u_dut5 (
      .i_clk (clk), .i_rst (rst), .bus (bus5.slave)
   );
   arith_op_sequencer #(.SLOTS_LOG2(3), .DWELL_W(16), .ALU_LAT(0)) u_dut0 (
      .i_clk (clk), .i_rst (rst), .bus (bus0.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".busy"}, 32'(bus1.o_busy), 0);
      check({tag, ".op"},   32'(bus1.o_opcode), 0);
      check({tag, ".slot"}, 32'(bus1.o_slot), 0);
      check({tag, ".ss"},   32'(bus1.o_slot_start), 0);
      check({tag, ".rv"},   32'(bus1.o_result_valid), 0);
      check({tag, ".rv0"},  32'(bus0.o_result_valid), 0);
   endtask

   // Program 0xE4, LastSlot 3, Dwell 2, single pass. With disturb set, the
   // live table changes to 0xFF and a second trigger edge arrives mid-run.
   task automatic run_single(input bit disturb);
      string t;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int i = 0; i < 12; i++) begin
         t = $sformatf("%s[%0d]", disturb ? "dist" : "single", i);
         check({t, ".op"},   32'(bus1.o_opcode), 32'(i / 3));
         check({t, ".slot"}, 32'(bus1.o_slot), 32'(i / 3));
         check({t, ".ss"},   32'(bus1.o_slot_start), 32'(i % 3 == 0));
         check({t, ".busy"}, 32'(bus1.o_busy), 1);
         check({t, ".done"}, 32'(bus1.o_done), 0);
         check({t, ".rv1"},  32'(bus1.o_result_valid), 32'(i % 3 != 0));
         check({t, ".rv5"},  32'(bus5.o_result_valid), 0);
         check({t, ".rv0"},  32'(bus0.o_result_valid), 1);
         if (disturb && i == 4) begin
            program_tbl = 16'h00FF;
            trigger     = 1'b1;
         end
         if (disturb && i == 6) trigger = 1'b0;
         tick();
      end
      t = disturb ? "dist_end" : "single_end";
      check({t, ".done"}, 32'(bus1.o_done), 1);
      check({t, ".done5"}, 32'(bus5.o_done), 1);
      check_idle(t);
      program_tbl = 16'h00E4;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; enable = 1'b1; trigger = 1'b1;
      program_tbl = 16'h00E4; last_slot = 3'd3; dwell = 16'd2; loop_en = 1'b0;
      repeat (3) tick();
      check_idle("reset");
      check("reset.done", 32'(bus1.o_done), 0);

      // Trigger held high through reset release: no start.
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("trig_hold[%0d].busy", i), 32'(bus1.o_busy), 0);
      end
      trigger = 1'b0;
      tick();

      run_single(1'b0);

      // Edge in the Done cycle restarts; then Enable low aborts silently.
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      check("restart.ss",   32'(bus1.o_slot_start), 1);
      check("restart.busy", 32'(bus1.o_busy), 1);
      check("restart.done", 32'(bus1.o_done), 0);
      enable = 1'b0;
      tick();
      check_idle("abort_en");
      check("abort_en.done", 32'(bus1.o_done), 0);
      enable = 1'b1;
      tick();
      check("abort_en2.done", 32'(bus1.o_done), 0);

      run_single(1'b1);
      tick();
      check("after_dist.done", 32'(bus1.o_done), 0);

      // Enable dropped during run cycle 5.
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("en_drop[%0d].busy", i), 32'(bus1.o_busy), 1);
         check($sformatf("en_drop[%0d].op", i), 32'(bus1.o_opcode), 32'(i / 3));
         if (i == 5) enable = 1'b0;
         tick();
      end
      check_idle("en_drop6");
      check("en_drop6.done", 32'(bus1.o_done), 0);
      tick();
      check("en_drop7.done", 32'(bus1.o_done), 0);
      trigger = 1'b1;
      tick();
      check("trig_noen.busy", 32'(bus1.o_busy), 0);
      tick();
      check("trig_noen2.busy", 32'(bus1.o_busy), 0);
      trigger = 1'b0;
      enable  = 1'b1;
      tick();

      // Loop with Dwell 0, then reset mid-run.
      loop_en = 1'b1;
      dwell   = 16'd0;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("loop[%0d].op", i),   32'(bus1.o_opcode), 32'(i % 4));
         check($sformatf("loop[%0d].slot", i), 32'(bus1.o_slot), 32'(i % 4));
         check($sformatf("loop[%0d].ss", i),   32'(bus1.o_slot_start), 1);
         check($sformatf("loop[%0d].done", i), 32'(bus1.o_done), 0);
         check($sformatf("loop[%0d].rv1", i),  32'(bus1.o_result_valid), 0);
         check($sformatf("loop[%0d].rv0", i),  32'(bus0.o_result_valid), 1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_mid");
      check("rst_mid.done", 32'(bus1.o_done), 0);
      tick();
      check("rst_mid2.done", 32'(bus1.o_done), 0);
      check("rst_mid2.busy", 32'(bus1.o_busy), 0);

      // Dwell 3 over two slots: latency behaviour per instance.
      loop_en   = 1'b0;
      dwell     = 16'd3;
      last_slot = 3'd1;
      trigger   = 1'b1;
      tick();
      trigger = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("lat[%0d].op", i),  32'(bus1.o_opcode), 32'(i / 4));
         check($sformatf("lat[%0d].ss", i),  32'(bus1.o_slot_start), 32'(i % 4 == 0));
         check($sformatf("lat[%0d].rv1", i), 32'(bus1.o_result_valid), 32'(i % 4 != 0));
         check($sformatf("lat[%0d].rv5", i), 32'(bus5.o_result_valid), 0);
         tick();
      end
      check("lat_end.done", 32'(bus1.o_done), 1);
      check("lat_end.busy", 32'(bus1.o_busy), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
